// File: rtl/framer_pkg.sv
// Shared types, limits and frame-length helper for the UART frame serializer.
// The BREAK state exists only when FRAMER_BREAK_EN is defined.
package framer_pkg;

  localparam int DATA_W_MIN_LIMIT = 5;
  localparam int DATA_W_MAX_LIMIT = 9;
  localparam logic [3:0] BREAK_TICKS = 4'd13;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10
  } parity_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
`ifdef FRAMER_BREAK_EN
    BREAK  = 3'd5,
`endif
    STOP   = 3'd4
  } state_t;

  // Total bit periods of a frame: start + data + optional parity + stop(s).
  function automatic logic [3:0] frame_len(input logic [3:0] len,
                                           input logic       par_en,
                                           input logic       stop2);
    return 4'd1 + len + {3'b000, par_en} + (stop2 ? 4'd2 : 4'd1);
  endfunction

endpackage

// File: rtl/frame_builder.sv
// Combinational frame assembly: clamps the data length, masks the word, computes
// parity and packs {stops, parity?, data} LSB-first. Independent of FRAMER_BREAK_EN.
module frame_builder
  import framer_pkg::*;
#(
  parameter int MAX_DATA_W = 8,
  parameter int MIN_DATA_W = 5
) (
  input  logic [MAX_DATA_W-1:0] data_i,
  input  logic [3:0]            len_i,
  input  logic [1:0]            parity_i,
  input  logic                  stop2_i,
  output logic [3:0]            len_o,
  output logic                  par_en_o,
  output logic [MAX_DATA_W+2:0] shift_o,
  output logic [3:0]            frame_bits_o
);

  localparam int SW = MAX_DATA_W + 3;
  localparam int LO = (MIN_DATA_W < DATA_W_MIN_LIMIT) ? DATA_W_MIN_LIMIT : MIN_DATA_W;
  localparam int HI = (MAX_DATA_W > DATA_W_MAX_LIMIT) ? DATA_W_MAX_LIMIT : MAX_DATA_W;

  logic [MAX_DATA_W-1:0] masked;
  logic                  par_bit;

  // Bits above the parity position stay 1 so they double as stop bits.
  always_comb begin
    len_o = len_i;
    if (len_i < 4'(LO)) len_o = 4'(LO);
    else if (len_i > 4'(HI)) len_o = 4'(HI);

    masked = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < int'(len_o)) masked[i] = data_i[i];
    end

    par_en_o = (parity_i == PAR_ODD) || (parity_i == PAR_EVEN);
    par_bit  = (^masked) ^ (parity_i == PAR_ODD);

    shift_o = '1;
    for (int i = 0; i < SW; i++) begin
      if (i < MAX_DATA_W && i < int'(len_o)) shift_o[i] = masked[i];
      else if (par_en_o && i == int'(len_o)) shift_o[i] = par_bit;
    end

    frame_bits_o = frame_len(len_o, par_en_o, stop2_i);
  end

endmodule

// File: rtl/frame_serializer.sv
// UART transmit serializer: valid/ready intake, frame FSM and LSB-first shifter.
// Define FRAMER_BREAK_EN to add the break_req input and the BREAK state.
module frame_serializer
  import framer_pkg::*;
#(
  parameter int MAX_DATA_W = 8,
  parameter int MIN_DATA_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  input  logic [MAX_DATA_W-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [3:0]            cfg_data_len,
  input  logic [1:0]            parity_type,
  input  logic                  stop_bits,
`ifdef FRAMER_BREAK_EN
  input  logic                  break_req,
`endif
  output logic                  tx,
  output logic                  tx_active,
  output logic                  frame_done
);

  localparam int SW = MAX_DATA_W + 3;

  state_t        state_q;
  logic [SW-1:0] shift_q;
  logic [3:0]    len_q, bit_cnt_q, tick_cnt_q, frame_bits_q;
  logic          par_en_q, tx_q, active_q, done_q;

  logic [3:0]    b_len, b_bits;
  logic          b_par_en;
  logic [SW-1:0] b_shift;
  logic          accept;

  frame_builder #(.MAX_DATA_W(MAX_DATA_W), .MIN_DATA_W(MIN_DATA_W)) u_builder (
    .data_i      (data_in),
    .len_i       (cfg_data_len),
    .parity_i    (parity_type),
    .stop2_i     (stop_bits),
    .len_o       (b_len),
    .par_en_o    (b_par_en),
    .shift_o     (b_shift),
    .frame_bits_o(b_bits)
  );

`ifdef FRAMER_BREAK_EN
  assign data_ready = (state_q == IDLE) && rst && !break_req;
`else
  assign data_ready = (state_q == IDLE) && rst;
`endif
  assign accept     = data_valid && data_ready;
  assign tx         = tx_q;
  assign tx_active  = active_q;
  assign frame_done = done_q;

  // Each tick emits the next shifter bit; ones shift in behind so parity/stop fall out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      shift_q      <= '1;
      len_q        <= '0;
      bit_cnt_q    <= '0;
      tick_cnt_q   <= '0;
      frame_bits_q <= '0;
      par_en_q     <= 1'b0;
      tx_q         <= 1'b1;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
`ifdef FRAMER_BREAK_EN
          if (break_req) begin
            state_q    <= BREAK;
            tx_q       <= 1'b0;
            active_q   <= 1'b1;
            tick_cnt_q <= '0;
          end else
`endif
          if (accept) begin
            state_q      <= START;
            shift_q      <= b_shift;
            len_q        <= b_len;
            par_en_q     <= b_par_en;
            frame_bits_q <= b_bits;
            bit_cnt_q    <= '0;
            tick_cnt_q   <= '0;
            tx_q         <= 1'b0;
            active_q     <= 1'b1;
          end
        end
        START, DATA, PARITY: if (baud_tick) begin
          tx_q       <= shift_q[0];
          shift_q    <= {1'b1, shift_q[SW-1:1]};
          tick_cnt_q <= tick_cnt_q + 4'd1;
          if (state_q == START) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
          end else if (state_q == PARITY) begin
            state_q <= STOP;
          end else if (bit_cnt_q == len_q - 4'd1) begin
            state_q <= par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        STOP: if (baud_tick) begin
          tx_q       <= 1'b1;
          tick_cnt_q <= tick_cnt_q + 4'd1;
          if (tick_cnt_q == frame_bits_q - 4'd1) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
            done_q   <= 1'b1;
          end
        end
`ifdef FRAMER_BREAK_EN
        BREAK: begin
          tx_q <= 1'b0;
          if (baud_tick && tick_cnt_q != BREAK_TICKS) tick_cnt_q <= tick_cnt_q + 4'd1;
          if (tick_cnt_q == BREAK_TICKS && !break_req) begin
            state_q  <= IDLE;
            tx_q     <= 1'b1;
            active_q <= 1'b0;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
// Directed self-checking bench for frame_serializer; the break tests build
// only when FRAMER_BREAK_EN is defined.
module tb_frame_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic [3:0] cfg_data_len = 4'd8;
  logic [1:0] parity_type = 2'b00;
  logic       stop_bits = 1'b0;
`ifdef FRAMER_BREAK_EN
  logic       break_req = 1'b0;
`endif
  logic       tx, tx_active, frame_done;

  int assertCount = 0;
  int failCount   = 0;

  frame_serializer #(.MAX_DATA_W(8), .MIN_DATA_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .cfg_data_len(cfg_data_len),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
`ifdef FRAMER_BREAK_EN
    .break_req   (break_req),
`endif
    .tx          (tx),
    .tx_active   (tx_active),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One bit period: a few idle cycles, then a single-cycle tick.
  task automatic doTick();
    repeat (2) @(negedge clk);
    baud_tick = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0;
  endtask

  // Present a word, wait for the handshake, then scramble config unless holding.
  task automatic applyStimulus(input logic [7:0] d, input logic [3:0] len, input logic [1:0] par,
                               input logic stop, input bit hold, input bit tickNow);
    int w = 0;
    data_in = d; cfg_data_len = len; parity_type = par; stop_bits = stop;
    data_valid = 1'b1;
    while (data_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("ready_wait", {31'b0, data_ready}, 32'd1);
    if (tickNow) baud_tick = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0;
    if (!hold) begin
      data_valid = 1'b0;
      data_in = ~d; cfg_data_len = 4'd6; parity_type = 2'b01; stop_bits = ~stop;
    end
  endtask

  // bits[k] is the k-th bit on the line, starting with the start bit.
  task automatic runFrame(input string tag, input logic [12:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("%s_bit%0d", tag, k), {31'b0, tx}, {31'b0, bits[k]});
      checkOutput($sformatf("%s_busy%0d", tag, k), {31'b0, tx_active}, 32'd1);
      checkOutput($sformatf("%s_nodone%0d", tag, k), {31'b0, frame_done}, 32'd0);
      doTick();
    end
    checkOutput({tag, "_done"}, {31'b0, frame_done}, 32'd1);
    checkOutput({tag, "_idle_active"}, {31'b0, tx_active}, 32'd0);
    checkOutput({tag, "_idle_tx"}, {31'b0, tx}, 32'd1);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, {31'b0, frame_done}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", {31'b0, tx}, 32'd1);
    checkOutput("rst_active", {31'b0, tx_active}, 32'd0);
    checkOutput("rst_done", {31'b0, frame_done}, 32'd0);
    checkOutput("rst_ready", {31'b0, data_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", {31'b0, data_ready}, 32'd1);

    // 8N1 0xA5, with a tick on the accept cycle that must be ignored
    applyStimulus(8'hA5, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1);
    runFrame("8N1_A5", {3'b000, 1'b1, 8'hA5, 1'b0}, 10);

    // 7E2 0x41: two ones -> even parity 0
    applyStimulus(8'h41, 4'd7, 2'b10, 1'b1, 1'b0, 1'b0);
    runFrame("7E2_41", {2'b00, 2'b11, 1'b0, 7'h41, 1'b0}, 11);

    // 8O1 0xFF and 0x00: both need parity 1
    applyStimulus(8'hFF, 4'd8, 2'b01, 1'b0, 1'b0, 1'b0);
    runFrame("8O1_FF", {2'b00, 1'b1, 1'b1, 8'hFF, 1'b0}, 11);
    applyStimulus(8'h00, 4'd8, 2'b01, 1'b0, 1'b0, 1'b0);
    runFrame("8O1_00", {2'b00, 1'b1, 1'b1, 8'h00, 1'b0}, 11);

    // len 3 clamps to 5: shortest frame, 7 ticks
    applyStimulus(8'hFF, 4'd3, 2'b00, 1'b0, 1'b0, 1'b0);
    runFrame("clamp_lo", {6'b000000, 1'b1, 5'h1F, 1'b0}, 7);

    // len 15 clamps to 8, parity code 11 means none
    applyStimulus(8'h3C, 4'd15, 2'b11, 1'b0, 1'b0, 1'b0);
    runFrame("clamp_hi", {3'b000, 1'b1, 8'h3C, 1'b0}, 10);

    // 5O1 0xE0: upper bits masked, so parity sees zero ones -> 1
    applyStimulus(8'hE0, 4'd5, 2'b01, 1'b0, 1'b0, 1'b0);
    runFrame("5O1_mask", {5'b00000, 1'b1, 1'b1, 5'h00, 1'b0}, 8);

    // 8E2 0x01: longest frame here, 12 ticks, parity 1
    applyStimulus(8'h01, 4'd8, 2'b10, 1'b1, 1'b0, 1'b0);
    runFrame("8E2_01", {1'b0, 2'b11, 1'b1, 8'h01, 1'b0}, 12);

    // Back-to-back with data_valid held high
    applyStimulus(8'h12, 4'd8, 2'b00, 1'b0, 1'b1, 1'b0);
    data_in = 8'h34;
    runFrame("b2b_12", {3'b000, 1'b1, 8'h12, 1'b0}, 10);
    data_valid = 1'b0;
    runFrame("b2b_34", {3'b000, 1'b1, 8'h34, 1'b0}, 10);

    // Reset during data bit 3 aborts the frame
    applyStimulus(8'hA5, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (4) doTick();
    checkOutput("abort_bit3", {31'b0, tx}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_tx", {31'b0, tx}, 32'd1);
    checkOutput("abort_active", {31'b0, tx_active}, 32'd0);
    checkOutput("abort_ready", {31'b0, data_ready}, 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      doTick();
      checkOutput($sformatf("abort_nodone%0d", k), {31'b0, frame_done}, 32'd0);
      checkOutput($sformatf("abort_idle%0d", k), {31'b0, tx}, 32'd1);
    end
    applyStimulus(8'h5A, 4'd8, 2'b00, 1'b0, 1'b0, 1'b0);
    runFrame("post_abort", {3'b000, 1'b1, 8'h5A, 1'b0}, 10);

`ifdef FRAMER_BREAK_EN
    // Break wins over a simultaneous data word, held for 20 ticks
    data_in = 8'h55; data_valid = 1'b1; break_req = 1'b1;
    #1;
    checkOutput("brk_wins_ready", {31'b0, data_ready}, 32'd0);
    @(negedge clk);
    data_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      checkOutput($sformatf("brk20_tx%0d", k), {31'b0, tx}, 32'd0);
      checkOutput($sformatf("brk20_act%0d", k), {31'b0, tx_active}, 32'd1);
      doTick();
    end
    break_req = 1'b0;
    @(negedge clk);
    checkOutput("brk20_exit_tx", {31'b0, tx}, 32'd1);
    checkOutput("brk20_exit_act", {31'b0, tx_active}, 32'd0);
    checkOutput("brk20_nodone", {31'b0, frame_done}, 32'd0);

    // Two-tick pulse still holds the line low for 13 ticks
    break_req = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 13; k++) begin
      checkOutput($sformatf("brk13_tx%0d", k), {31'b0, tx}, 32'd0);
      doTick();
      if (k == 1) break_req = 1'b0;
    end
    @(negedge clk);
    checkOutput("brk13_exit_tx", {31'b0, tx}, 32'd1);
    checkOutput("brk13_exit_act", {31'b0, tx_active}, 32'd0);
    checkOutput("brk13_ready", {31'b0, data_ready}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
